// File: rtl/store_buffer.sv
// store_buffer
//
// Post-commit store buffer. It sits between the ROB store-commit port and
// data memory. Retired stores are queued in program order and written to
// memory one at a time over a req/ack handshake. Younger loads that probe
// the buffer get forwarded data, or a conflict flag when the youngest
// matching store only partially covers them. Committed stores are
// architectural, so nothing here can flush the queue.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   commit_*            store pushed by the ROB; commit_stall = buffer full
//   mem_*               head-entry write request; mem_ack pops the head
//   load_*              combinational forwarding probe
//   fwd_hit/value       load fully covered by the youngest matching store
//   fwd_conflict        partial overlap with a byte store; load must stall
//   empty               nothing held (fences, drain waits)

module store_buffer #(
    parameter int ADDRESS_SIZE  = 32,
    parameter int REGISTER_SIZE = 32,
    parameter int ENTRIES       = 4,
    parameter int PTR_SIZE      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     commit_req,
    input  logic [ADDRESS_SIZE-1:0]  commit_address,
    input  logic [REGISTER_SIZE-1:0] commit_data,
    input  logic                     commit_b,
    output logic                     commit_stall,
    output logic                     mem_req,
    output logic [ADDRESS_SIZE-1:0]  mem_address,
    output logic [REGISTER_SIZE-1:0] mem_data,
    output logic                     mem_b,
    input  logic                     mem_ack,
    input  logic [ADDRESS_SIZE-1:0]  load_address,
    input  logic                     load_b,
    input  logic                     load_valid,
    output logic                     fwd_hit,
    output logic [REGISTER_SIZE-1:0] fwd_value,
    output logic                     fwd_conflict,
    output logic                     empty
);

    logic [ENTRIES-1:0]       valid_q;
    logic [ADDRESS_SIZE-1:0]  addr_q [ENTRIES];
    logic [REGISTER_SIZE-1:0] data_q [ENTRIES];
    logic [ENTRIES-1:0]       b_q;

    logic [PTR_SIZE-1:0] head_q, head_d;
    logic [PTR_SIZE-1:0] tail_q, tail_d;
    logic [PTR_SIZE:0]   count_q, count_d;

    logic push, pop;

    assign commit_stall = (count_q == (PTR_SIZE + 1)'(ENTRIES));
    assign empty        = (count_q == '0);
    assign mem_req      = !empty;
    assign push         = commit_req && !commit_stall;
    assign pop          = mem_req && mem_ack;

    // Head fields are masked when idle so stale drained data never shows.
    assign mem_address = mem_req ? addr_q[head_q] : '0;
    assign mem_data    = mem_req ? data_q[head_q] : '0;
    assign mem_b       = mem_req && b_q[head_q];

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (push) tail_d = tail_q + 1'b1;
        if (pop)  head_d = head_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            b_q     <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Push and pop never hit the same slot: a push needs a free slot,
            // a pop needs an occupied one.
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                addr_q[tail_q]  <= commit_address;
                data_q[tail_q]  <= commit_data;
                b_q[tail_q]     <= commit_b;
            end
            if (pop) valid_q[head_q] <= 1'b0;
        end
    end

    // Forwarding: walk oldest to youngest so the last match is the youngest.
    logic [PTR_SIZE-1:0]      idx;
    logic [PTR_SIZE-1:0]      sel;
    logic                     found;
    logic [ADDRESS_SIZE-1:0]  sel_addr;
    logic [REGISTER_SIZE-1:0] sel_data;
    logic [7:0]               sel_lane;

    always_comb begin
        idx   = '0;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            idx = head_q + PTR_SIZE'(i);
            if (valid_q[idx] &&
                addr_q[idx][ADDRESS_SIZE-1:2] == load_address[ADDRESS_SIZE-1:2]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign sel_addr = addr_q[sel];
    assign sel_data = data_q[sel];
    assign sel_lane = sel_data[{load_address[1:0], 3'b000} +: 8];

    always_comb begin
        fwd_hit      = 1'b0;
        fwd_conflict = 1'b0;
        fwd_value    = '0;
        if (load_valid && found) begin
            if (!b_q[sel]) begin
                fwd_hit   = 1'b1;
                fwd_value = load_b ? {{(REGISTER_SIZE-8){1'b0}}, sel_lane} : sel_data;
            end else if (load_b && sel_addr[1:0] == load_address[1:0]) begin
                fwd_hit   = 1'b1;
                fwd_value = {{(REGISTER_SIZE-8){1'b0}}, sel_data[7:0]};
            end else begin
                fwd_conflict = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int EN = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        commit_req, commit_b, commit_stall;
    logic [31:0] commit_address, commit_data;
    logic        mem_req, mem_b, mem_ack;
    logic [31:0] mem_address, mem_data;
    logic [31:0] load_address;
    logic        load_b, load_valid;
    logic        fwd_hit, fwd_conflict, empty;
    logic [31:0] fwd_value;

    store_buffer #(.ADDRESS_SIZE(32), .REGISTER_SIZE(32), .ENTRIES(EN), .PTR_SIZE(2)) dut (
        .clk(clk), .reset(reset),
        .commit_req(commit_req), .commit_address(commit_address),
        .commit_data(commit_data), .commit_b(commit_b), .commit_stall(commit_stall),
        .mem_req(mem_req), .mem_address(mem_address), .mem_data(mem_data),
        .mem_b(mem_b), .mem_ack(mem_ack),
        .load_address(load_address), .load_b(load_b), .load_valid(load_valid),
        .fwd_hit(fwd_hit), .fwd_value(fwd_value), .fwd_conflict(fwd_conflict),
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        b;
    } st_t;

    st_t mq[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: youngest matching store decides, scanning the queue from the back.
    task automatic model_fwd(output logic h, output logic c, output logic [31:0] v);
        h = 0; c = 0; v = 0;
        if (load_valid) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].addr[31:2] == load_address[31:2]) begin
                    if (!mq[i].b) begin
                        h = 1;
                        v = load_b ? ((mq[i].data >> (8 * load_address[1:0])) & 32'hFF) : mq[i].data;
                    end else if (load_b && mq[i].addr[1:0] == load_address[1:0]) begin
                        h = 1;
                        v = mq[i].data & 32'hFF;
                    end else begin
                        c = 1;
                    end
                    break;
                end
            end
        end
    endtask

    task automatic check_model();
        logic h, c;
        logic [31:0] v;
        model_fwd(h, c, v);
        chk("stall",   commit_stall, (mq.size() == EN) ? 1 : 0);
        chk("mem_req", mem_req,      (mq.size() != 0) ? 1 : 0);
        chk("empty",   empty,        (mq.size() == 0) ? 1 : 0);
        if (mq.size() != 0) begin
            chk("mem_addr", mem_address, mq[0].addr);
            chk("mem_data", mem_data,    mq[0].data);
            chk("mem_b",    mem_b,       mq[0].b);
        end
        chk("fwd_hit",  fwd_hit,      h);
        chk("fwd_conf", fwd_conflict, c);
        chk("fwd_val",  fwd_value,    v);
    endtask

    // Called after the negedge checks; commits the model at the next rising edge.
    task automatic advance();
        bit   do_push, do_pop;
        st_t  e;
        do_push = commit_req && (mq.size() < EN);
        do_pop  = mem_ack && (mq.size() > 0);
        e.addr = commit_address; e.data = commit_data; e.b = commit_b;
        @(posedge clk);
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(e);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        advance();
    endtask

    task automatic set_in(input logic cr, input logic [31:0] ca, input logic [31:0] cd,
                          input logic cb, input logic ack, input logic [31:0] la,
                          input logic lb, input logic lv);
        commit_req = cr; commit_address = ca; commit_data = cd; commit_b = cb;
        mem_ack = ack; load_address = la; load_b = lb; load_valid = lv;
    endtask

    typedef struct {
        logic        cr;
        logic [31:0] ca;
        logic [31:0] cd;
        logic        cb;
        logic        ack;
        logic [31:0] la;
        logic        lb;
        logic        lv;
        logic        e_stall;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_empty;
        logic        e_hit;
        logic [31:0] e_val;
        logic        e_conf;
    } vec_t;

    vec_t tv[18];

    initial begin
        //            cr  ca        cd            cb ack la        lb lv   stl req addr      emp hit val           conf
        tv[0]  = '{1, 32'h2000, 32'h11223344, 0, 0, 32'h0000, 0, 0,  0, 0, 32'h0000, 1, 0, 32'h0,        0};
        tv[1]  = '{1, 32'h2000, 32'hAABBCCDD, 0, 0, 32'h2000, 0, 1,  0, 1, 32'h2000, 0, 1, 32'h11223344, 0};
        tv[2]  = '{0, 32'h0,    32'h0,        0, 0, 32'h2000, 0, 1,  0, 1, 32'h2000, 0, 1, 32'hAABBCCDD, 0};
        tv[3]  = '{0, 32'h0,    32'h0,        0, 0, 32'h2002, 1, 1,  0, 1, 32'h2000, 0, 1, 32'h000000BB, 0};
        tv[4]  = '{0, 32'h0,    32'h0,        0, 0, 32'h2003, 1, 1,  0, 1, 32'h2000, 0, 1, 32'h000000AA, 0};
        tv[5]  = '{1, 32'h3001, 32'hFFFFFF5A, 1, 0, 32'h2000, 1, 1,  0, 1, 32'h2000, 0, 1, 32'h000000DD, 0};
        tv[6]  = '{0, 32'h0,    32'h0,        0, 0, 32'h3001, 1, 1,  0, 1, 32'h2000, 0, 1, 32'h0000005A, 0};
        tv[7]  = '{0, 32'h0,    32'h0,        0, 0, 32'h3000, 1, 1,  0, 1, 32'h2000, 0, 0, 32'h0,        1};
        tv[8]  = '{0, 32'h0,    32'h0,        0, 0, 32'h3000, 0, 1,  0, 1, 32'h2000, 0, 0, 32'h0,        1};
        tv[9]  = '{0, 32'h0,    32'h0,        0, 0, 32'h4000, 0, 1,  0, 1, 32'h2000, 0, 0, 32'h0,        0};
        tv[10] = '{1, 32'h5000, 32'h01020304, 0, 0, 32'h2000, 0, 0,  0, 1, 32'h2000, 0, 0, 32'h0,        0};
        tv[11] = '{1, 32'h6000, 32'h66666666, 0, 1, 32'h2000, 0, 1,  1, 1, 32'h2000, 0, 1, 32'hAABBCCDD, 0};
        tv[12] = '{1, 32'h6000, 32'h66666666, 0, 0, 32'h6000, 0, 1,  0, 1, 32'h2000, 0, 0, 32'h0,        0};
        tv[13] = '{0, 32'h0,    32'h0,        0, 1, 32'h2000, 0, 1,  1, 1, 32'h2000, 0, 1, 32'hAABBCCDD, 0};
        tv[14] = '{0, 32'h0,    32'h0,        0, 1, 32'h2000, 0, 1,  0, 1, 32'h3001, 0, 0, 32'h0,        0};
        tv[15] = '{0, 32'h0,    32'h0,        0, 1, 32'h5000, 0, 1,  0, 1, 32'h5000, 0, 1, 32'h01020304, 0};
        tv[16] = '{0, 32'h0,    32'h0,        0, 1, 32'h6001, 1, 1,  0, 1, 32'h6000, 0, 1, 32'h00000066, 0};
        tv[17] = '{0, 32'h0,    32'h0,        0, 1, 32'h6000, 0, 1,  0, 0, 32'h0000, 1, 0, 32'h0,        0};
    end

    initial begin
        logic [31:0] drained[$];
        int n;

        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_stall", commit_stall, 0);
        chk("rst_req",   mem_req,      0);
        chk("rst_addr",  mem_address,  0);
        chk("rst_data",  mem_data,     0);
        chk("rst_b",     mem_b,        0);
        chk("rst_empty", empty,        1);
        chk("rst_hit",   fwd_hit,      0);
        chk("rst_conf",  fwd_conflict, 0);
        chk("rst_val",   fwd_value,    0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic push then drain.
        set_in(1, 32'h1000, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("basic_req",   mem_req,     1);
        chk("basic_addr",  mem_address, 32'h1000);
        chk("basic_data",  mem_data,    32'hDEADBEEF);
        chk("basic_empty", empty,       0);
        advance();
        mem_ack = 1;
        step();
        mem_ack = 0;
        @(negedge clk);
        chk("basic_req2",   mem_req, 0);
        chk("basic_empty2", empty,   1);
        advance();

        // Directed vector table.
        for (int k = 0; k < 18; k++) begin
            set_in(tv[k].cr, tv[k].ca, tv[k].cd, tv[k].cb, tv[k].ack, tv[k].la, tv[k].lb, tv[k].lv);
            @(negedge clk);
            chk($sformatf("v%0d_stall", k), commit_stall, tv[k].e_stall);
            chk($sformatf("v%0d_req",   k), mem_req,      tv[k].e_req);
            chk($sformatf("v%0d_addr",  k), mem_address,  tv[k].e_addr);
            chk($sformatf("v%0d_empty", k), empty,        tv[k].e_empty);
            chk($sformatf("v%0d_hit",   k), fwd_hit,      tv[k].e_hit);
            chk($sformatf("v%0d_val",   k), fwd_value,    tv[k].e_val);
            chk($sformatf("v%0d_conf",  k), fwd_conflict, tv[k].e_conf);
            advance();
        end

        // Full-rate streaming with ack held high: never stalls, drains in order.
        n = 0;
        for (int k = 0; k < 11; k++) begin
            set_in(k < 8, 32'h700 + 32'(4 * k), 32'hC0DE0000 + 32'(k), 0, 1, 0, 0, 0);
            @(negedge clk);
            check_model();
            chk("tp_stall", commit_stall, 0);
            if (mem_req && mem_ack) drained.push_back(mem_address);
            advance();
        end
        chk("tp_count", drained.size(), 8);
        foreach (drained[i]) chk($sformatf("tp_order%0d", i), drained[i], 32'h700 + 32'(4 * i));

        // Randomised traffic, including pointer wrap and full-buffer stalls.
        for (int k = 0; k < 400; k++) begin
            logic b;
            logic [31:0] a, la;
            b  = 1'($urandom_range(0, 1));
            a  = 32'h100 + 32'(4 * $urandom_range(0, 3));
            if (b) a = a + 32'($urandom_range(0, 3));
            la = 32'h100 + 32'(4 * $urandom_range(0, 4)) + 32'($urandom_range(0, 3));
            set_in(1'($urandom_range(0, 1)), a, $urandom, b, 1'($urandom_range(0, 2) == 0),
                   la, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            if (!load_b) load_address[1:0] = 2'b00;
            step();
        end

        // Asynchronous reset in the middle of a drain.
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        while (mq.size() != 0) begin mem_ack = 1; step(); end
        for (int k = 0; k < 3; k++) begin
            set_in(1, 32'h900 + 32'(4 * k), 32'h5500 + 32'(k), 0, 0, 32'h900, 0, 1);
            step();
        end
        set_in(0, 0, 0, 0, 0, 32'h900, 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_req",   mem_req,      0);
        chk("arst_stall", commit_stall, 0);
        chk("arst_empty", empty,        1);
        chk("arst_hit",   fwd_hit,      0);
        chk("arst_conf",  fwd_conflict, 0);
        mq.delete();
        @(negedge clk);
        reset = 1'b0;
        mem_ack = 1;
        for (int k = 0; k < 4; k++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Post-commit store buffer between the ROB store-commit port and data memory.
- The ROB pushes retired stores in program order. The block drains them to data memory one at a time over a req/ack handshake.
- Same-address younger loads in the memory pipeline get forwarded data or a conflict flag, so they never read stale memory.
- Committed stores are architectural: the buffer is never flushed by a branch or a clear.

Parameters:
- ADDRESS_SIZE, 32, width of byte addresses
- REGISTER_SIZE, 32, width of store and load data
- ENTRIES, 4, buffer depth; must be a power of two, at least 2
- PTR_SIZE, 2, log2(ENTRIES)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- commit_req  input  1  ROB presents a committed store this cycle
- commit_address  input  ADDRESS_SIZE  store byte address
- commit_data  input  REGISTER_SIZE  store data; byte stores use [7:0]
- commit_b  input  1  1 = byte store, 0 = word store
- commit_stall  output  1  buffer full; ROB must hold its store
- mem_req  output  1  head entry valid, write requested
- mem_address  output  ADDRESS_SIZE  head entry address
- mem_data  output  REGISTER_SIZE  head entry data
- mem_b  output  1  head entry byte flag
- mem_ack  input  1  memory accepted the head write this cycle
- load_address  input  ADDRESS_SIZE  address of the load probing the buffer
- load_b  input  1  probing load is a byte load
- load_valid  input  1  probe is active
- fwd_hit  output  1  load fully satisfied from the buffer
- fwd_value  output  REGISTER_SIZE  forwarded load data
- fwd_conflict  output  1  partial overlap; the load must stall
- empty  output  1  no entries held (used for fences and drain waits)

Behaviour:
- Storage and state
  - Circular FIFO of ENTRIES entries: {valid, address, data, b}.
  - head and tail are PTR_SIZE-bit pointers; count is PTR_SIZE+1 bits. All wrap modulo ENTRIES.
- Reset (asynchronous)
  - head=0, tail=0, count=0, all valid=0.
  - Outputs at reset: commit_stall=0, mem_req=0, mem_address=0, mem_data=0, mem_b=0, fwd_hit=0, fwd_value=0, fwd_conflict=0, empty=1.
  - A reset asserted mid-drain discards pending entries and drops mem_req immediately.
- Push
  - Occurs when commit_req && !commit_stall.
  - Entry written at tail on the rising edge; tail increments; the entry becomes visible to drain and forwarding the next cycle.
  - commit_stall = (count == ENTRIES). It is combinational from registered count. There is no same-cycle pop bypass: a full buffer stalls even if mem_ack is high.
- Drain
  - mem_req = (count != 0). mem_address, mem_data and mem_b come from the head entry and stay stable while mem_req && !mem_ack.
  - When mem_ack && mem_req: head entry invalidated and head increments at the edge.
  - mem_ack while mem_req=0 is ignored.
  - Throughput is at most one store per cycle with mem_ack held high. The drain latency from push to earliest ack is 1 cycle.
- Simultaneous push and pop: count unchanged, both pointers advance.
- empty = (count == 0).
- Forwarding (combinational, only when load_valid=1; otherwise fwd_hit=0, fwd_conflict=0, fwd_value=0)
  - An entry overlaps the load when valid and address[ADDRESS_SIZE-1:2] == load_address[ADDRESS_SIZE-1:2].
  - Select E, the youngest overlapping entry, searching from tail-1 back to head.
  - E word store, word load: hit; fwd_value = E.data.
  - E word store, byte load: hit; fwd_value = zero-extended byte lane load_address[1:0] of E.data. Lane 0 is [7:0], lane 3 is [31:24].
  - E byte store, byte load, same address[1:0]: hit; fwd_value = {zeros, E.data[7:0]}.
  - E byte store, any other load: fwd_conflict=1, fwd_hit=0.
  - No overlapping entry: fwd_hit=0, fwd_conflict=0.
  - fwd_hit and fwd_conflict are never both 1.
  - The entry at head that is being acked this cycle still participates in forwarding; it leaves at the edge.
  - A same-cycle commit is not visible to the probe.
- Arithmetic: pointer arithmetic wraps naturally. Addresses are not aligned by the block; word stores must be word-aligned by the producer.

Test Plan:
- Reset, then push word 0x1000=0xDEADBEEF with mem_ack=0 -> next cycle mem_req=1, mem_address=0x1000, mem_data=0xDEADBEEF, empty=0. Assert mem_ack one cycle -> mem_req=0, empty=1.
- Push 4 stores with mem_ack=0 -> commit_stall=1. A 5th commit_req is held and not written. Ack once -> commit_stall=0 next cycle. The 5th store enters. Drain order matches push order across pointer wrap.
- Entries: word 0x2000=0x11223344, then word 0x2000=0xAABBCCDD. Probe word load 0x2000 -> fwd_hit=1, fwd_value=0xAABBCCDD. Probe byte load 0x2002 -> fwd_value=0x000000BB.
- Byte store 0x3001=0x5A. Probe byte 0x3001 -> hit, 0x0000005A. Probe byte 0x3000 -> fwd_conflict=1. Probe word 0x3000 -> fwd_conflict=1. Probe 0x4000 -> no hit, no conflict.
- Hold mem_ack=1 and push every cycle for 8 cycles -> count stays at 1 at most, commit_stall never asserts, 8 writes leave in order.
- Push 3 stores, assert reset asynchronously mid-cycle -> mem_req, commit_stall, fwd_hit and fwd_conflict drop immediately and empty=1. After release, no stale entry drains.
